// File: rtl/matrix_transposed_convolution.sv
// 2x2 input by 2x2 kernel stride-1 transposed convolution.
// Scatters one input element per cycle into nine accumulators.
module matrix_transposed_convolution #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [DATA_W-1:0] kern_0,
  input  logic [DATA_W-1:0] kern_1,
  input  logic [DATA_W-1:0] kern_2,
  input  logic [DATA_W-1:0] kern_3,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [DATA_W-1:0] out_4,
  output logic [DATA_W-1:0] out_5,
  output logic [DATA_W-1:0] out_6,
  output logic [DATA_W-1:0] out_7,
  output logic [DATA_W-1:0] out_8
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCATTER,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] in_r   [4];
  logic [DATA_W-1:0] kern_r [4];
  logic [DATA_W-1:0] acc    [9];
  logic [DATA_W-1:0] acc_nx [9];
  logic [DATA_W-1:0] res    [9];
  logic [DATA_W-1:0] x;
  logic [1:0]        step;
  logic [3:0]        base;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD:    state_nx = SCATTER;
      SCATTER: if (step == 2'd3) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input element (r,c) lands on the 2x2 window whose top-left is (r,c)
  always_comb begin
    acc_nx = acc;
    x      = in_r[step];
    base   = {3'b0, step[0]} + (step[1] ? 4'd3 : 4'd0);
    acc_nx[base]        = acc[base]        + x * kern_r[0];
    acc_nx[base + 4'd1] = acc[base + 4'd1] + x * kern_r[1];
    acc_nx[base + 4'd3] = acc[base + 4'd3] + x * kern_r[2];
    acc_nx[base + 4'd4] = acc[base + 4'd4] + x * kern_r[3];
  end

  // Capture, accumulate and publish the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        in_r[i]   <= '0;
        kern_r[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        acc[i] <= '0;
        res[i] <= '0;
      end
      step <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            in_r[0]   <= in_0;
            in_r[1]   <= in_1;
            in_r[2]   <= in_2;
            in_r[3]   <= in_3;
            kern_r[0] <= kern_0;
            kern_r[1] <= kern_1;
            kern_r[2] <= kern_2;
            kern_r[3] <= kern_3;
          end
        end
        LOAD: begin
          for (int i = 0; i < 9; i++) acc[i] <= '0;
          step <= '0;
        end
        SCATTER: begin
          acc  <= acc_nx;
          step <= step + 2'd1;
          if (step == 2'd3) res <= acc_nx;
        end
        default: ;
      endcase
    end
  end

  assign out_0 = res[0];
  assign out_1 = res[1];
  assign out_2 = res[2];
  assign out_3 = res[3];
  assign out_4 = res[4];
  assign out_5 = res[5];
  assign out_6 = res[6];
  assign out_7 = res[7];
  assign out_8 = res[8];

endmodule

// File: tb/tb_matrix_transposed_convolution.sv
// Bench for matrix_transposed_convolution.
// Directed and random ops against a scatter-sum reference.
module tb_matrix_transposed_convolution;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_0, in_1, in_2, in_3;
  logic [31:0] kern_0, kern_1, kern_2, kern_3;
  logic        busy, done;
  logic [31:0] out_0, out_1, out_2, out_3, out_4;
  logic [31:0] out_5, out_6, out_7, out_8;

  logic [31:0] o    [9];
  logic [31:0] ti   [4];
  logic [31:0] tk   [4];
  logic [31:0] expv [9];
  logic [31:0] prev [9];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_transposed_convolution #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in_0   (in_0),
    .in_1   (in_1),
    .in_2   (in_2),
    .in_3   (in_3),
    .kern_0 (kern_0),
    .kern_1 (kern_1),
    .kern_2 (kern_2),
    .kern_3 (kern_3),
    .busy   (busy),
    .done   (done),
    .out_0  (out_0),
    .out_1  (out_1),
    .out_2  (out_2),
    .out_3  (out_3),
    .out_4  (out_4),
    .out_5  (out_5),
    .out_6  (out_6),
    .out_7  (out_7),
    .out_8  (out_8)
  );

  assign o[0] = out_0;
  assign o[1] = out_1;
  assign o[2] = out_2;
  assign o[3] = out_3;
  assign o[4] = out_4;
  assign o[5] = out_5;
  assign o[6] = out_6;
  assign o[7] = out_7;
  assign o[8] = out_8;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: every input element times every kernel element,
  // summed into the output cell at the sum of their coordinates.
  function automatic void model();
    for (int k = 0; k < 9; k++) expv[k] = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int kr = 0; kr < 2; kr++)
          for (int kc = 0; kc < 2; kc++)
            expv[(r + kr) * 3 + c + kc] += ti[r * 2 + c] * tk[kr * 2 + kc];
  endfunction

  task automatic drive_t();
    in_0 = ti[0]; in_1 = ti[1]; in_2 = ti[2]; in_3 = ti[3];
    kern_0 = tk[0]; kern_1 = tk[1]; kern_2 = tk[2]; kern_3 = tk[3];
  endtask

  task automatic drive_junk();
    in_0 = $urandom; in_1 = $urandom; in_2 = $urandom; in_3 = $urandom;
    kern_0 = $urandom; kern_1 = $urandom;
    kern_2 = $urandom; kern_3 = $urandom;
  endtask

  function automatic logic [31:0] rval();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic rand_t();
    for (int i = 0; i < 4; i++) begin
      ti[i] = rval();
      tk[i] = rval();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_out%0d", tag, k), o[k], 32'd0);
  endtask

  // Called at a negedge in IDLE. mode 1 disturbs inputs and start
  // mid-op; rst_at > 0 asserts reset in that cycle.
  task automatic run_op(input int mode, input int rst_at);
    model();
    drive_t();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_c%0d", c), {31'b0, busy}, 32'(c <= 6));
      chk($sformatf("done_c%0d", c), {31'b0, done}, 32'(c == 6));
      for (int k = 0; k < 9; k++)
        chk($sformatf("out%0d_c%0d", k, c), o[k],
            (c >= 6) ? expv[k] : prev[k]);
      if (mode == 1 && (c == 3 || c == 4)) begin
        in_0 = 32'd9; in_1 = 32'd9; in_2 = 32'd9; in_3 = 32'd9;
        kern_0 = 32'd9;
        start = 1'b1;
      end
      if (rst_at == c) begin
        reset = 1'b1;
        #1;
        chk_zero($sformatf("rst_c%0d", c));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) prev[k] = '0;
        return;
      end
    end
    for (int k = 0; k < 9; k++) prev[k] = expv[k];
  endtask

  // Three operations with start held high continuously
  task automatic b2b();
    logic [31:0] ep [3][9];
    rand_t();
    model();
    for (int k = 0; k < 9; k++) ep[0][k] = expv[k];
    drive_t();
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", c), {31'b0, done},
          32'((c % 7 == 6) && c <= 20));
      chk($sformatf("b2b_busy_c%0d", c), {31'b0, busy},
          32'((c % 7 != 0) && c <= 20));
      if (c % 7 == 6 && c <= 20)
        for (int k = 0; k < 9; k++)
          chk($sformatf("b2b_out%0d_c%0d", k, c), o[k], ep[c / 7][k]);
      if (c % 7 == 0 && c <= 14) begin
        rand_t();
        model();
        for (int k = 0; k < 9; k++) ep[c / 7][k] = expv[k];
        drive_t();
      end else begin
        drive_junk();
      end
      if (c == 15) start = 1'b0;
    end
    for (int k = 0; k < 9; k++) prev[k] = ep[2][k];
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ti[i] = '0;
      tk[i] = '0;
    end
    drive_t();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) prev[k] = '0;

    ti = '{32'd1, 32'd2, 32'd3, 32'd4};
    tk = '{32'd1, 32'd0, 32'd1, 32'd0};
    run_op(0, 0);
    chk("ref_out4", o[4], 32'd6);

    ti = '{32'd1, 32'd1, 32'd1, 32'd1};
    tk = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_op(0, 0);
    chk("ones_out4", o[4], 32'd4);

    ti = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_op(0, 0);

    ti = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_op(0, 0);
    chk("wrap_out4", o[4], 32'hFFFFFFFC);
    chk("wrap_out0", o[0], 32'hFFFFFFFF);
    chk("wrap_out1", o[1], 32'hFFFFFFFE);

    ti = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    tk = '{32'd2, 32'd0, 32'd0, 32'd0};
    run_op(0, 0);
    chk("wrap1_out0", o[0], 32'hFFFFFFFE);

    ti = '{32'd1, 32'd2, 32'd3, 32'd4};
    tk = '{32'd1, 32'd0, 32'd1, 32'd0};
    run_op(1, 0);

    ti = '{32'd1, 32'd1, 32'd1, 32'd1};
    tk = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_op(0, 0);
    ti = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_op(0, 3);
    ti = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_op(0, 0);

    ti = '{32'd2, 32'd3, 32'd4, 32'd5};
    run_op(0, 6);

    for (int n = 0; n < 8; n++) begin
      rand_t();
      run_op(int'($urandom_range(0, 1)), 0);
    end

    b2b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
